// File: rtl/move_arbiter.sv
// Per-frame movement scheduler for the two fighters. Every MOVE_DIV frame ticks it
// samples both fighters, grants move pulses so the sprites never overlap, and drives the collision flag.
module move_arbiter #(
    parameter int MOVE_DIV   = 3,
    parameter int CHAR_WIDTH = 128,
    parameter int STEP_FWD0  = 3,
    parameter int STEP_FWD1  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic [3:0] state0,
    input  logic [3:0] state1,
    input  logic [9:0] x0,
    input  logic [9:0] x1,
    output logic       move_en0,
    output logic       move_en1,
    output logic       collision,
    output logic       rr_ptr
);

    localparam logic [1:0] S_WAIT   = 2'd0;
    localparam logic [1:0] S_SAMPLE = 2'd1;
    localparam logic [1:0] S_DECIDE = 2'd2;
    localparam logic [1:0] S_ISSUE  = 2'd3;

    localparam logic [3:0] ST_LEFT  = 4'd1;
    localparam logic [3:0] ST_RIGHT = 4'd2;

    localparam logic [3:0]        DIV_LAST  = 4'(MOVE_DIV - 1);
    localparam logic signed [10:0] STEP0    = 11'(STEP_FWD0);
    localparam logic signed [10:0] STEP1    = 11'(STEP_FWD1);
    localparam logic signed [10:0] STEP_SUM = 11'(STEP_FWD0 + STEP_FWD1);
    localparam logic        [10:0] WIDTH    = 11'(CHAR_WIDTH);

    logic [1:0]         fsm;
    logic [3:0]         div_cnt;
    logic [3:0]         st0_q;
    logic [3:0]         st1_q;
    logic [9:0]         x0_q;
    logic [9:0]         x1_q;
    logic signed [10:0] gap;

    logic fwd0, fwd1, away0, away1;
    logic ok0, ok1;
    logic grant0, grant1, rr_next;

    assign fwd0  = (st0_q == ST_RIGHT);
    assign away0 = (st0_q == ST_LEFT);
    assign fwd1  = (st1_q == ST_LEFT);
    assign away1 = (st1_q == ST_RIGHT);
    assign ok0   = (gap >= STEP0);
    assign ok1   = (gap >= STEP1);

    // Contested approaches: the priority holder is tried first, then the other fighter.
    always_comb begin
        grant0  = 1'b0;
        grant1  = 1'b0;
        rr_next = rr_ptr;
        if (fwd0 && fwd1) begin
            if (gap >= STEP_SUM) begin
                grant0 = 1'b1;
                grant1 = 1'b1;
            end else begin
                if (!rr_ptr) begin
                    if (ok0)      grant0 = 1'b1;
                    else if (ok1) grant1 = 1'b1;
                end else begin
                    if (ok1)      grant1 = 1'b1;
                    else if (ok0) grant0 = 1'b1;
                end
                if (grant0)      rr_next = 1'b1;
                else if (grant1) rr_next = 1'b0;
            end
        end else begin
            grant0 = away0 | (fwd0 & ok0);
            grant1 = away1 | (fwd1 & ok1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm       <= S_WAIT;
            div_cnt   <= 4'd0;
            st0_q     <= 4'd0;
            st1_q     <= 4'd0;
            x0_q      <= 10'd0;
            x1_q      <= 10'd0;
            gap       <= 11'sd0;
            move_en0  <= 1'b0;
            move_en1  <= 1'b0;
            collision <= 1'b0;
            rr_ptr    <= 1'b0;
        end else begin
            move_en0 <= 1'b0;
            move_en1 <= 1'b0;
            case (fsm)
                S_WAIT: begin
                    if (frame_tick) begin
                        if (div_cnt == DIV_LAST) begin
                            div_cnt <= 4'd0;
                            fsm     <= S_SAMPLE;
                        end else begin
                            div_cnt <= div_cnt + 4'd1;
                        end
                    end
                end
                S_SAMPLE: begin
                    st0_q <= state0;
                    st1_q <= state1;
                    x0_q  <= x0;
                    x1_q  <= x1;
                    // Zero-extended to 11 bits so an overlap goes negative instead of wrapping.
                    gap   <= $signed({1'b0, x1}) - $signed({1'b0, x0}) - $signed(WIDTH);
                    fsm   <= S_DECIDE;
                end
                S_DECIDE: begin
                    move_en0  <= grant0;
                    move_en1  <= grant1;
                    collision <= (gap < STEP1);
                    rr_ptr    <= rr_next;
                    fsm       <= S_ISSUE;
                end
                default: begin
                    fsm <= S_WAIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_move_arbiter.sv
// Randomised scoreboard bench for move_arbiter: a slot-level reference model queues
// the expected response for each movement slot and a negedge monitor compares every cycle.
module tb_move_arbiter;

    localparam int MOVE_DIV   = 3;
    localparam int CHAR_WIDTH = 128;
    localparam int STEP_FWD0  = 3;
    localparam int STEP_FWD1  = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       frame_tick;
    logic [3:0] state0, state1;
    logic [9:0] x0, x1;
    logic       move_en0, move_en1, collision, rr_ptr;

    move_arbiter #(
        .MOVE_DIV(MOVE_DIV), .CHAR_WIDTH(CHAR_WIDTH),
        .STEP_FWD0(STEP_FWD0), .STEP_FWD1(STEP_FWD1)
    ) dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick),
        .state0(state0), .state1(state1), .x0(x0), .x1(x1),
        .move_en0(move_en0), .move_en1(move_en1),
        .collision(collision), .rr_ptr(rr_ptr)
    );

    always #5 clk = ~clk;

    typedef struct {
        int due;
        bit en0;
        bit en1;
        bit coll;
        bit rr;
    } exp_t;

    exp_t sb[$];
    int   cyc       = 0;
    int   ticks     = 0;
    int   sample_at = -1;
    int   free_from = 0;
    bit   model_rr  = 1'b0;
    bit   cur_coll  = 1'b0;
    bit   cur_rr    = 1'b0;
    int   checks    = 0;
    int   errors    = 0;

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Slot decision straight from the movement rules, using plain integer arithmetic.
    task automatic modelDecide();
        exp_t e;
        int   g;
        bit   f0, f1, a0, a1, g0, g1;
        g  = int'(x1) - int'(x0) - CHAR_WIDTH;
        f0 = (state0 == 4'd2);
        a0 = (state0 == 4'd1);
        f1 = (state1 == 4'd1);
        a1 = (state1 == 4'd2);
        g0 = 1'b0;
        g1 = 1'b0;
        if (f0 && f1) begin
            if (g >= STEP_FWD0 + STEP_FWD1) begin
                g0 = 1'b1;
                g1 = 1'b1;
            end else begin
                for (int k = 0; k < 2; k++) begin
                    bit who;
                    who = (k == 0) ? model_rr : !model_rr;
                    if (!g0 && !g1 && g >= (who ? STEP_FWD1 : STEP_FWD0)) begin
                        if (who) g1 = 1'b1;
                        else     g0 = 1'b1;
                    end
                end
                if (g0)      model_rr = 1'b1;
                else if (g1) model_rr = 1'b0;
            end
        end else begin
            g0 = a0 || (f0 && g >= STEP_FWD0);
            g1 = a1 || (f1 && g >= STEP_FWD1);
        end
        e.due  = cyc + 1;
        e.en0  = g0;
        e.en1  = g1;
        e.coll = (g < STEP_FWD1);
        e.rr   = model_rr;
        sb.push_back(e);
    endtask

    // Reference model: counts qualifying ticks, ignores ticks while a slot is in flight.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (rst) begin
                sb.delete();
                ticks     = 0;
                sample_at = -1;
                free_from = 0;
                model_rr  = 1'b0;
                cur_coll  = 1'b0;
                cur_rr    = 1'b0;
            end else begin
                if (cyc == sample_at) begin
                    modelDecide();
                    sample_at = -1;
                end
                if (frame_tick && cyc >= free_from) begin
                    if (ticks == MOVE_DIV - 1) begin
                        ticks     = 0;
                        sample_at = cyc + 1;
                        free_from = cyc + 4;
                    end else begin
                        ticks++;
                    end
                end
            end
        end
    end

    // Monitor: pops the expectation due this cycle, otherwise pulses must be low.
    initial begin
        forever begin
            bit en0, en1;
            @(negedge clk);
            en0 = 1'b0;
            en1 = 1'b0;
            if (sb.size() > 0 && sb[0].due <= cyc) begin
                exp_t e;
                e = sb.pop_front();
                if (e.due != cyc) checkOutput("sb_due", cyc, e.due);
                en0      = e.en0;
                en1      = e.en1;
                cur_coll = e.coll;
                cur_rr   = e.rr;
            end
            checkOutput("move_en0", int'(move_en0), int'(en0));
            checkOutput("move_en1", int'(move_en1), int'(en1));
            checkOutput("collision", int'(collision), int'(cur_coll));
            checkOutput("rr_ptr", int'(rr_ptr), int'(cur_rr));
        end
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus(input logic [3:0] s0, input logic [3:0] s1,
                                 input int px0, input int px1,
                                 input int n_ticks, input int spacing);
        @(negedge clk);
        state0 = s0;
        state1 = s1;
        x0     = 10'(px0);
        x1     = 10'(px1);
        for (int i = 0; i < n_ticks; i++) begin
            frame_tick = 1'b1;
            @(negedge clk);
            frame_tick = 1'b0;
            repeat (spacing - 1) @(negedge clk);
        end
    endtask

    initial begin
        rst        = 1'b1;
        frame_tick = 1'b0;
        state0     = 4'd0;
        state1     = 4'd0;
        x0         = 10'd0;
        x1         = 10'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        applyStimulus(4'd2, 4'd0, 80, 400, 6, 10);
        applyStimulus(4'd2, 4'd1, 100, 233, 3, 10);
        applyStimulus(4'd2, 4'd1, 100, 231, 6, 10);
        applyStimulus(4'd2, 4'd1, 100, 230, 3, 10);
        applyStimulus(4'd2, 4'd1, 100, 229, 3, 10);
        applyStimulus(4'd1, 4'd1, 100, 228, 3, 10);
        applyStimulus(4'd0, 4'd0, 100, 300, 1, 8);

        // Abort a slot in DECIDE, then ensure busy-time ticks are not counted.
        state0 = 4'd2;
        state1 = 4'd1;
        x0     = 10'd100;
        x1     = 10'd300;
        for (int i = 0; i < 20; i++) begin
            frame_tick = 1'b1;
            @(negedge clk);
            frame_tick = 1'b0;
            if (sample_at >= 0) break;
        end
        checkOutput("slot_started", int'(sample_at >= 0), 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(4'd2, 4'd1, 100, 300, 6, 2);
        applyStimulus(4'd2, 4'd1, 100, 300, 6, 1);

        for (int i = 0; i < 300; i++) begin
            int px0, gp;
            px0 = int'($urandom_range(0, 400));
            if ($urandom_range(0, 3) != 0) gp = int'($urandom_range(0, 16)) - 6;
            else                           gp = int'($urandom_range(0, 300));
            applyStimulus(4'($urandom_range(0, 4)), 4'($urandom_range(0, 4)),
                          px0, px0 + CHAR_WIDTH + gp, 1, int'($urandom_range(1, 5)));
        end

        repeat (8) @(negedge clk);
        checkOutput("sb_drain", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
